// File: rtl/fft_pkg.sv
// Shared FFT result-reader definitions: widths, complex word layout,
// bin-index bit reversal and the reader state encoding.
package fft_pkg;

    localparam int FFT_ADDR_W = 8;
    localparam int FFT_DATA_W = 32;

    // Result word: upper half real, lower half imaginary, both signed.
    typedef struct packed {
        logic signed [FFT_DATA_W/2-1:0] re;
        logic signed [FFT_DATA_W/2-1:0] im;
    } cplx_t;

    typedef enum logic {
        FILL = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // Reverse the low w bits of v; bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame buffer: synchronous write, synchronous read with
// one cycle of latency. The read register holds its value while re is low,
// which lets the top use it directly as the output data register.
module fft_frame_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port; data only advances on an issued read.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_result_reader.sv
// FFT result reader: captures a frame of FFT_FSM result writes into a local
// buffer, then streams it out in bin order over valid/ready with a last mark.
// Optional build macro FFT_READER_BITREV_EN: read the buffer at the
// bit-reversed pointer so a bit-reversed write order comes out natural.
module fft_result_reader
    import fft_pkg::*;
#(
    parameter int ADDR_W = FFT_ADDR_W,
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_overrun
);

    rd_state_t         state, state_n;
    // Extra MSB marks "all N reads issued" so the pointer never wraps.
    logic [ADDR_W:0]   ptr, ptr_n;
    logic              valid, valid_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic              last, last_n;
    logic              overrun, overrun_n;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;

`ifdef FFT_READER_BITREV_EN
    assign raddr = ADDR_W'(bitrev(32'(ptr[ADDR_W-1:0]), ADDR_W));
`else
    assign raddr = ptr[ADDR_W-1:0];
`endif

    fft_frame_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .waddr (i_waddr),
        .wdata (i_wdata),
        .re    (ram_re),
        .raddr (raddr),
        .rdata (rdata)
    );

    // State, read pointer, output stage and sticky overrun registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= FILL;
            ptr     <= '0;
            valid   <= 1'b0;
            idx     <= '0;
            last    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            valid   <= valid_n;
            idx     <= idx_n;
            last    <= last_n;
            overrun <= overrun_n;
        end
    end

    // Next-state: fill on writes, then issue reads whenever the output
    // stage is empty or being consumed; i_en low overrides everything.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        valid_n   = valid;
        idx_n     = idx;
        last_n    = last;
        overrun_n = overrun;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        if (!i_en) begin
            state_n   = FILL;
            ptr_n     = '0;
            valid_n   = 1'b0;
            idx_n     = '0;
            last_n    = 1'b0;
            overrun_n = 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (i_wr) begin
                        ram_we = 1'b1;
                        if (&i_waddr) begin
                            state_n = READ;
                            ptr_n   = '0;
                        end
                    end
                end
                READ: begin
                    if (i_wr) overrun_n = 1'b1;
                    if (!ptr[ADDR_W] && (!valid || i_ready)) begin
                        ram_re  = 1'b1;
                        ptr_n   = ptr + (ADDR_W+1)'(1);
                        valid_n = 1'b1;
                        idx_n   = ptr[ADDR_W-1:0];
                        last_n  = &ptr[ADDR_W-1:0];
                    end else if (valid && i_ready) begin
                        valid_n = 1'b0;
                    end
                    if (valid && i_ready && last) begin
                        state_n = FILL;
                        ptr_n   = '0;
                    end
                end
                default: state_n = FILL;
            endcase
        end
    end

    // The RAM read register is not reset, so qualify the payload with valid.
    assign o_valid   = valid;
    assign o_data    = valid ? rdata : '0;
    assign o_idx     = valid ? idx : '0;
    assign o_last    = valid & last;
    assign o_busy    = (state == READ);
    assign o_overrun = overrun;

endmodule
